mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_timeout_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the datapath it steers:
// FSM state encoding, timeout default and the mux/direction encodings.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAddr   = 3'd1,
        StStrobe = 3'd2,
        StDone   = 3'd3,
        StErr    = 3'd4
    } state_e;

    localparam int unsigned TimeoutDefault = 15;
    localparam int unsigned TimeoutWidth   = 4;

    // Memory direction on RW
    localparam logic RwRead  = 1'b1;
    localparam logic RwWrite = 1'b0;

    // MAR mux: program counter or ALU result
    localparam logic MarSelPc  = 1'b0;
    localparam logic MarSelAlu = 1'b1;

    // MDR mux: ALU result or memory DataOut
    localparam logic MdrSelAlu = 1'b0;
    localparam logic MdrSelMem = 1'b1;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts STROBE cycles without MOC. tc_o flags the enabled cycle in which the
// count reaches Terminal, so the owner can leave on that same edge.
module mem_timeout_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned Terminal = TimeoutDefault
) (
    input  logic Clk,
    input  logic Clr,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TimeoutWidth-1:0] LastBeforeTc = TimeoutWidth'(Terminal - 1);

    logic [TimeoutWidth-1:0] count_q, count_d;

    // Next count: synchronous clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TimeoutWidth'(1);
        end
        tc_o = en_i && (count_q == LastBeforeTc);
    end

    // Count register with asynchronous clear
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data load/store for a
// single RAM port. Sequences MAR/MDR/IR loads, the MOV strobe and the ACKs,
// and traps into a sticky error state when MOC never returns.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic Clk,
    input  logic Clr,
    input  logic if_req,
    output logic if_ack,
    input  logic ds_req,
    input  logic ds_we,
    output logic ds_ack,
    output logic mar_sel,
    output logic MAR_Ld,
    output logic MDR_Ld,
    output logic IR_Ld,
    output logic mdr_sel,
    output logic MOV,
    output logic RW,
    input  logic MOC,
    output logic busy,
    output logic timeout_err
);

    state_e state_q, state_d;
    logic   gnt_data_q, gnt_data_d;
    logic   we_q, we_d;
    logic   last_data_q, last_data_d;
    logic   pick_data;
    logic   is_store;
    logic   tmo_tc;

    // Data wins unless fetch is also pending and data had the last grant
    assign pick_data = ds_req && (!if_req || !last_data_q);
    assign is_store  = gnt_data_q && we_q;

    mem_timeout_counter #(
        .Terminal (TIMEOUT)
    ) u_timeout (
        .Clk   (Clk),
        .Clr   (Clr),
        .clr_i (state_q == StAddr),
        .en_i  ((state_q == StStrobe) && !MOC),
        .tc_o  (tmo_tc)
    );

    // Next-state and grant bookkeeping
    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        we_d        = we_q;
        last_data_d = last_data_q;
        unique case (state_q)
            StIdle: begin
                if (if_req || ds_req) begin
                    gnt_data_d  = pick_data;
                    we_d        = pick_data && ds_we;
                    last_data_d = pick_data;
                    state_d     = StAddr;
                end
            end
            StAddr:   state_d = StStrobe;
            StStrobe: begin
                // Completion beats timeout when both land in the same cycle
                if (MOC) begin
                    state_d = StDone;
                end else if (tmo_tc) begin
                    state_d = StErr;
                end
            end
            StDone:   state_d = StIdle;
            StErr:    state_d = StErr;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode; only the completion loads look at MOC
    always_comb begin
        if_ack      = 1'b0;
        ds_ack      = 1'b0;
        mar_sel     = MarSelPc;
        MAR_Ld      = 1'b0;
        MDR_Ld      = 1'b0;
        IR_Ld       = 1'b0;
        mdr_sel     = MdrSelAlu;
        MOV         = 1'b0;
        RW          = RwWrite;
        busy        = (state_q != StIdle);
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: ;
            StAddr: begin
                MAR_Ld  = 1'b1;
                mar_sel = gnt_data_q ? MarSelAlu : MarSelPc;
                if (is_store) begin
                    MDR_Ld  = 1'b1;
                    mdr_sel = MdrSelAlu;
                end
            end
            StStrobe: begin
                MOV = 1'b1;
                RW  = is_store ? RwWrite : RwRead;
                if (MOC) begin
                    if (!gnt_data_q) begin
                        IR_Ld = 1'b1;
                    end else if (!we_q) begin
                        MDR_Ld  = 1'b1;
                        mdr_sel = MdrSelMem;
                    end
                end
            end
            StDone: begin
                ds_ack = gnt_data_q;
                if_ack = !gnt_data_q;
            end
            StErr:   timeout_err = 1'b1;
            default: ;
        endcase
    end

    // State and grant registers; last grant resets to data so fetch wins first
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q     <= StIdle;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            last_data_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            we_q        <= we_d;
            last_data_q <= last_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle expected output words are
// queued as stimulus is driven and compared at the following falling edge.
module tb_mem_arbiter;

    logic Clk = 1'b0;
    logic Clr;
    logic if_req, ds_req, ds_we, MOC;
    logic if_ack, ds_ack, mar_sel, MAR_Ld, MDR_Ld, IR_Ld, mdr_sel, MOV, RW, busy, timeout_err;

    always #5 Clk = ~Clk;

    mem_arbiter #(
        .TIMEOUT (15)
    ) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .if_req      (if_req),
        .if_ack      (if_ack),
        .ds_req      (ds_req),
        .ds_we       (ds_we),
        .ds_ack      (ds_ack),
        .mar_sel     (mar_sel),
        .MAR_Ld      (MAR_Ld),
        .MDR_Ld      (MDR_Ld),
        .IR_Ld       (IR_Ld),
        .mdr_sel     (mdr_sel),
        .MOV         (MOV),
        .RW          (RW),
        .MOC         (MOC),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic busy;
        logic mar_ld;
        logic mar_sel;
        logic mdr_ld;
        logic mdr_sel;
        logic ir_ld;
        logic mov;
        logic rw;
        logic if_ack;
        logic ds_ack;
        logic timeout_err;
    } out_t;

    typedef enum {PIdle, PAddr, PStrobe, PDone, PErr} phase_e;

    typedef struct {
        out_t  w;
        string tag;
    } exp_t;

    typedef struct {
        logic        is_data;
        logic        we;
        int unsigned wait_cyc;
        logic        drop;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    out_t act;

    assign act = {busy, MAR_Ld, mar_sel, MDR_Ld, mdr_sel, IR_Ld, MOV, RW, if_ack, ds_ack,
                  timeout_err};

    // Reference model of the outputs for one cycle of a transaction
    function automatic out_t exp_word(input phase_e ph, input logic d, input logic we,
                                      input logic moc);
        out_t o;
        o = '0;
        case (ph)
            PAddr: begin
                o.busy    = 1'b1;
                o.mar_ld  = 1'b1;
                o.mar_sel = d;
                o.mdr_ld  = d && we;
            end
            PStrobe: begin
                o.busy = 1'b1;
                o.mov  = 1'b1;
                o.rw   = !(d && we);
                if (moc) begin
                    o.ir_ld   = !d;
                    o.mdr_ld  = d && !we;
                    o.mdr_sel = d && !we;
                end
            end
            PDone: begin
                o.busy   = 1'b1;
                o.if_ack = !d;
                o.ds_ack = d;
            end
            PErr: begin
                o.busy        = 1'b1;
                o.timeout_err = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%b exp=%b (busy,marld,marsel,mdrld,mdrsel,irld,mov,rw,ifack,dsack,err)",
                     name, a, e);
        end
    endtask

    // Scoreboard consumer: compare one queued word per cycle mid-cycle
    always @(negedge Clk) begin : sb_check
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, act, e.w);
        end
    end

    task automatic step(input out_t w, input string tag);
        exp_t e;
        e.w   = w;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_access(input vec_t v, input string tag);
        if_req = !v.is_data;
        ds_req = v.is_data;
        ds_we  = v.we;
        MOC    = 1'b0;
        step(exp_word(PIdle, v.is_data, v.we, 1'b0), {tag, " idle"});
        if (v.drop) begin
            if_req = 1'b0;
            ds_req = 1'b0;
            ds_we  = !v.we;
        end
        step(exp_word(PAddr, v.is_data, v.we, 1'b0), {tag, " addr"});
        for (int j = 0; j <= int'(v.wait_cyc); j++) begin
            MOC = (j == int'(v.wait_cyc));
            step(exp_word(PStrobe, v.is_data, v.we, MOC), $sformatf("%s strobe%0d", tag, j));
        end
        MOC    = 1'b0;
        if_req = 1'b0;
        ds_req = 1'b0;
        step(exp_word(PDone, v.is_data, v.we, 1'b0), {tag, " done"});
        step(exp_word(PIdle, v.is_data, v.we, 1'b0), {tag, " after"});
    endtask

    task automatic pulse_clr();
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        Clr = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[8];
        vecs[0] = '{1'b0, 1'b0, 0,  1'b0};  // fetch, immediate MOC
        vecs[1] = '{1'b1, 1'b1, 3,  1'b0};  // store, 3 wait cycles
        vecs[2] = '{1'b1, 1'b0, 0,  1'b0};  // load, immediate MOC
        vecs[3] = '{1'b1, 1'b0, 2,  1'b1};  // load, requester drops early
        vecs[4] = '{1'b0, 1'b0, 1,  1'b1};  // fetch, requester drops early
        vecs[5] = '{1'b1, 1'b1, 0,  1'b0};  // store, immediate MOC
        vecs[6] = '{1'b1, 1'b0, 14, 1'b0};  // MOC in the cycle count hits TIMEOUT
        vecs[7] = '{1'b0, 1'b0, 5,  1'b0};  // fetch, 5 wait cycles

        Clr    = 1'b1;
        if_req = 1'b0;
        ds_req = 1'b0;
        ds_we  = 1'b0;
        MOC    = 1'b0;
        #2;
        check("reset", act, '0);
        @(posedge Clk);
        #1;
        Clr = 1'b0;

        foreach (vecs[i]) do_access(vecs[i], $sformatf("v%0d", i));

        // MOC while idle with nothing pending must be ignored
        MOC = 1'b1;
        for (int i = 0; i < 3; i++) step('0, $sformatf("moc idle %0d", i));
        do_access(vecs[0], "post moc idle");

        // Continuous contention: fetch first after reset, then alternate
        pulse_clr();
        if_req = 1'b1;
        ds_req = 1'b1;
        ds_we  = 1'b0;
        MOC    = 1'b1;
        step('0, "rr idle");
        for (int n = 0; n < 4; n++) begin
            logic d;
            d = (n % 2) == 1;
            step(exp_word(PAddr, d, 1'b0, 1'b0), $sformatf("rr%0d addr", n));
            step(exp_word(PStrobe, d, 1'b0, 1'b1), $sformatf("rr%0d strobe", n));
            if (n == 3) begin
                if_req = 1'b0;
                ds_req = 1'b0;
            end
            step(exp_word(PDone, d, 1'b0, 1'b0), $sformatf("rr%0d done", n));
            step('0, $sformatf("rr%0d idle", n));
        end

        // Load whose MOC never returns: 15 strobe cycles then sticky error
        pulse_clr();
        ds_req = 1'b1;
        ds_we  = 1'b0;
        MOC    = 1'b0;
        step('0, "tmo idle");
        step(exp_word(PAddr, 1'b1, 1'b0, 1'b0), "tmo addr");
        for (int j = 0; j < 15; j++) begin
            step(exp_word(PStrobe, 1'b1, 1'b0, 1'b0), $sformatf("tmo strobe%0d", j));
        end
        for (int j = 0; j < 4; j++) begin
            MOC = j[0];
            step(exp_word(PErr, 1'b1, 1'b0, 1'b0), $sformatf("tmo err%0d", j));
        end
        Clr = 1'b1;
        #1;
        check("tmo clr async", act, '0);
        @(posedge Clk);
        #1;
        Clr    = 1'b0;
        ds_req = 1'b0;
        MOC    = 1'b0;
        step('0, "tmo cleared");

        // Clr mid-STROBE drops everything at once; next fetch is clean
        if_req = 1'b1;
        step('0, "clr idle");
        step(exp_word(PAddr, 1'b0, 1'b0, 1'b0), "clr addr");
        step(exp_word(PStrobe, 1'b0, 1'b0, 1'b0), "clr strobe0");
        step(exp_word(PStrobe, 1'b0, 1'b0, 1'b0), "clr strobe1");
        #2;
        Clr = 1'b1;
        #1;
        check("clr mid strobe", act, '0);
        @(posedge Clk);
        #1;
        Clr    = 1'b0;
        if_req = 1'b0;
        do_access(vecs[0], "after clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
